// File: rtl/chaining_record_table_if.sv
// chaining_record_table_if: alloc/write/retire request bus and per-slot record bundle of the chaining record table
// master drives alloc_*, write_*, retire_* and observes alloc_ready, record_*, occupancy; slave is the table.
interface chaining_record_table_if #(
    parameter int ENTRIES = 4,
    parameter int MASK_W = 256
);
    localparam int OCC_W = $clog2(ENTRIES + 1);
    logic                      alloc_valid;
    logic                      alloc_ready;
    logic                      alloc_vd_valid;
    logic [4:0]                alloc_vd_bits;
    logic                      alloc_vs1_valid;
    logic [4:0]                alloc_vs1_bits;
    logic [4:0]                alloc_vs2;
    logic [2:0]                alloc_instIndex;
    logic                      alloc_gather;
    logic                      alloc_gather16;
    logic                      alloc_onlyRead;
    logic                      write_valid;
    logic [4:0]                write_vd;
    logic [4:0]                write_offset;
    logic [2:0]                write_instIndex;
    logic                      retire_valid;
    logic [2:0]                retire_instIndex;
    logic [ENTRIES-1:0]        record_valid;
    logic [ENTRIES-1:0]        record_vd_valid;
    logic [ENTRIES-1:0]        record_vs1_valid;
    logic [ENTRIES-1:0]        record_gather;
    logic [ENTRIES-1:0]        record_gather16;
    logic [ENTRIES-1:0]        record_onlyRead;
    logic [5*ENTRIES-1:0]      record_vd_bits;
    logic [5*ENTRIES-1:0]      record_vs1_bits;
    logic [5*ENTRIES-1:0]      record_vs2;
    logic [3*ENTRIES-1:0]      record_instIndex;
    logic [MASK_W*ENTRIES-1:0] record_elementMask;
    logic [OCC_W-1:0]          occupancy;
    modport master (
        output alloc_valid, alloc_vd_valid, alloc_vd_bits, alloc_vs1_valid, alloc_vs1_bits, alloc_vs2,
               alloc_instIndex, alloc_gather, alloc_gather16, alloc_onlyRead,
               write_valid, write_vd, write_offset, write_instIndex, retire_valid, retire_instIndex,
        input  alloc_ready, record_valid, record_vd_valid, record_vs1_valid, record_gather, record_gather16,
               record_onlyRead, record_vd_bits, record_vs1_bits, record_vs2, record_instIndex,
               record_elementMask, occupancy
    );
    modport slave (
        input  alloc_valid, alloc_vd_valid, alloc_vd_bits, alloc_vs1_valid, alloc_vs1_bits, alloc_vs2,
               alloc_instIndex, alloc_gather, alloc_gather16, alloc_onlyRead,
               write_valid, write_vd, write_offset, write_instIndex, retire_valid, retire_instIndex,
        output alloc_ready, record_valid, record_vd_valid, record_vs1_valid, record_gather, record_gather16,
               record_onlyRead, record_vd_bits, record_vs1_bits, record_vs2, record_instIndex,
               record_elementMask, occupancy
    );
endinterface

// File: rtl/chaining_record_table.sv
// chaining_record_table: in-flight instruction records with per-element write masks for VRF write-hazard checks
// Ports: clock, reset (async, active-high); bus (slave) carries alloc/write/retire requests and the registered record bundle.
module chaining_record_table #(
    parameter int ENTRIES = 4,
    parameter int MASK_W = 256
) (
    input logic clock,
    input logic reset,
    chaining_record_table_if.slave bus
);
    localparam int SW = $clog2(ENTRIES);
    localparam int OW = $clog2(ENTRIES + 1);
    logic [ENTRIES-1:0]             valid_q, valid_d, vdv_q, vdv_d, vs1v_q, vs1v_d;
    logic [ENTRIES-1:0]             gth_q, gth_d, g16_q, g16_d, ordo_q, ordo_d;
    logic [ENTRIES-1:0][4:0]        vd_q, vd_d, vs1_q, vs1_d, vs2_q, vs2_d;
    logic [ENTRIES-1:0][2:0]        idx_q, idx_d;
    logic [ENTRIES-1:0][MASK_W-1:0] mask_q, mask_d;
    logic [OW-1:0]                  occ_q, occ_d;
    logic [SW-1:0]                  free_idx;
    logic                           alloc_fire;
    assign bus.alloc_ready        = ~&valid_q;
    assign bus.record_valid       = valid_q;
    assign bus.record_vd_valid    = vdv_q;
    assign bus.record_vs1_valid   = vs1v_q;
    assign bus.record_gather      = gth_q;
    assign bus.record_gather16    = g16_q;
    assign bus.record_onlyRead    = ordo_q;
    assign bus.record_vd_bits     = vd_q;
    assign bus.record_vs1_bits    = vs1_q;
    assign bus.record_vs2         = vs2_q;
    assign bus.record_instIndex   = idx_q;
    assign bus.record_elementMask = mask_q;
    assign bus.occupancy          = occ_q;
    assign alloc_fire = bus.alloc_valid & ~&valid_q;
    // Lowest-index free slot: scanning downward lets the lowest hit win.
    always_comb begin
        free_idx = '0;
        for (int i = ENTRIES - 1; i >= 0; i--)
            if (!valid_q[i]) free_idx = SW'(i);
    end
    always_comb begin
        valid_d = valid_q;
        vdv_d   = vdv_q;
        vs1v_d  = vs1v_q;
        gth_d   = gth_q;
        g16_d   = g16_q;
        ordo_d  = ordo_q;
        vd_d    = vd_q;
        vs1_d   = vs1_q;
        vs2_d   = vs2_q;
        idx_d   = idx_q;
        mask_d  = mask_q;
        occ_d   = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            // The allocated slot is free, so no write or retire can match it this cycle.
            if (alloc_fire && free_idx == SW'(i)) begin
                valid_d[i] = 1'b1;
                vdv_d[i]   = bus.alloc_vd_valid;
                vs1v_d[i]  = bus.alloc_vs1_valid;
                gth_d[i]   = bus.alloc_gather;
                g16_d[i]   = bus.alloc_gather16;
                ordo_d[i]  = bus.alloc_onlyRead;
                vd_d[i]    = bus.alloc_vd_bits;
                vs1_d[i]   = bus.alloc_vs1_bits;
                vs2_d[i]   = bus.alloc_vs2;
                idx_d[i]   = bus.alloc_instIndex;
                mask_d[i]  = '0;
            end else begin
                // Mask row is the register distance from the group base, wrapping within 8 registers.
                if (bus.write_valid && valid_q[i] && vdv_q[i] && idx_q[i] == bus.write_instIndex)
                    mask_d[i][{3'(bus.write_vd[2:0] - vd_q[i][2:0]), bus.write_offset}] = 1'b1;
                if (bus.retire_valid && valid_q[i] && idx_q[i] == bus.retire_instIndex)
                    valid_d[i] = 1'b0;
            end
            occ_d = occ_d + OW'(valid_d[i]);
        end
    end
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            valid_q <= '0;
            vdv_q   <= '0;
            vs1v_q  <= '0;
            gth_q   <= '0;
            g16_q   <= '0;
            ordo_q  <= '0;
            vd_q    <= '0;
            vs1_q   <= '0;
            vs2_q   <= '0;
            idx_q   <= '0;
            mask_q  <= '0;
            occ_q   <= '0;
        end else begin
            valid_q <= valid_d;
            vdv_q   <= vdv_d;
            vs1v_q  <= vs1v_d;
            gth_q   <= gth_d;
            g16_q   <= g16_d;
            ordo_q  <= ordo_d;
            vd_q    <= vd_d;
            vs1_q   <= vs1_d;
            vs2_q   <= vs2_d;
            idx_q   <= idx_d;
            mask_q  <= mask_d;
            occ_q   <= occ_d;
        end
    end
endmodule

// File: doc/chaining_record_table.md
# chaining_record_table

Holds the in-flight instruction records that the lane's VRF write-hazard checkers compare pending writes against. Instructions are allocated into free slots at issue. Each slot's element-completion mask is updated as that instruction's VRF writes land, and the slot is freed at retire. The block exposes every slot as a registered record bundle, in exactly the field layout the write checkers consume.

## Interface
Parameters:
- ENTRIES, 4, number of record slots (2..8)
- MASK_W, 256, element-mask width: 8 registers x 32 elements per register group

Ports:
- clock  in  1  sole clock
- reset  in  1  asynchronous, active-high
- alloc_valid  in  1  issue request
- alloc_ready  out  1  a free slot exists
- alloc_vd_valid / alloc_vd_bits  in  1 / 5  destination register group
- alloc_vs1_valid / alloc_vs1_bits  in  1 / 5  source 1
- alloc_vs2  in  5  source 2
- alloc_instIndex  in  3  instruction tag
- alloc_gather, alloc_gather16, alloc_onlyRead  in  1 each  record flags
- write_valid  in  1  one element written to the VRF this cycle
- write_vd  in  5  register written
- write_offset  in  5  element offset within that register
- write_instIndex  in  3  tag of the writing instruction
- retire_valid / retire_instIndex  in  1 / 3  instruction finished
- record_valid  out  ENTRIES  per-slot valid
- record_vd_valid, record_vs1_valid, record_gather, record_gather16, record_onlyRead  out  ENTRIES each  per-slot flags
- record_vd_bits, record_vs1_bits, record_vs2  out  5*ENTRIES each  slot i occupies bits [5i+4:5i]
- record_instIndex  out  3*ENTRIES
- record_elementMask  out  MASK_W*ENTRIES  bit set = element already written
- occupancy  out  $clog2(ENTRIES+1)  count of valid slots

## Operation
Reset values:
- All record outputs are 0.
- occupancy = 0.
- alloc_ready = 1.

Allocation:
- An allocation fires when alloc_valid & alloc_ready.
- The target is the lowest-index slot with valid = 0.
- The slot captures all alloc fields.
- elementMask is cleared to all zeros, and valid is set.
- alloc_ready = ~&record_valid, computed from registered state only. A same-cycle retire does not bypass into alloc_ready.

Element write:
- While write_valid, every slot with valid & vd_valid & instIndex == write_instIndex sets one mask bit.
- Bit index = {(write_vd[2:0] - record_vd_bits[2:0]) mod 8, write_offset}, 8 bits.
- The subtraction wraps in 3 bits, so a write to base+7 lands at bits 224..255 and a write to base+8 wraps to bit 0..31.
- Writes whose tag matches no valid slot are ignored, as are writes to slots with vd_valid = 0.
- Bits only ever set; they are never cleared except by re-allocation.

Retire:
- While retire_valid, every valid slot with instIndex == retire_instIndex clears valid.
- Its other fields keep their values; the mask is irrelevant once valid = 0.

Simultaneous events, same cycle:
- Write and retire on the same slot: retire wins; the slot is invalid next cycle.
- Alloc into slot k with a write tagged the new instIndex: the slot starts with an all-zero mask and the write is dropped.
- Retire of slot j and alloc into a different free slot k: both take effect.
- Alloc while full: no change, since alloc_ready = 0.
- Duplicate instIndex allocation is an upstream protocol error. The block does not check for it; write and retire then update all matching slots.

Occupancy: occupancy = popcount(record_valid), registered, updated together with valid.

## Timing
- All outputs are registered.
- Allocation is visible on record_* and occupancy at cycle N+1.
- A write accepted at cycle N is visible in record_elementMask at N+1.
- Retire at cycle N drops record_valid at N+1. alloc_ready rises at N+1 if the table was full.
- Throughput: 1 alloc + 1 write + 1 retire per cycle.
- Reset asserted mid-operation immediately and asynchronously clears all valid bits, masks and occupancy. It also forces alloc_ready = 1. Inputs are ignored while reset is high.

## Test plan
- Reset then alloc {vd=8, vd_valid=1, instIndex=2}. Required at next cycle:
  - record_valid = 0001, occupancy = 1
  - slot 0 vd_bits = 8, mask = 0
- Slot 0 with vd=8; write {vd=9, offset=3, tag=2}:
  - mask bit 35 set, all others 0
- Same slot; write {vd=15, offset=31}:
  - bit 255 set
- Same slot; write vd=16:
  - bit 31-offset wrap, bit index {0,offset}
- Fill 4 slots (tags 0..3):
  - alloc_ready = 0; a 5th alloc is ignored
- Full table; retire tag 1 and alloc tag 4 in the same cycle:
  - alloc is not accepted
  - next cycle: slot 1 is free, alloc_ready = 1, occupancy = 3
  - an alloc then lands in slot 1
- Write and retire tag 2 in the same cycle:
  - slot invalid next cycle
  - the mask write has no effect on any other slot
- Write with an unmatched tag 6:
  - all masks unchanged
- Assert reset asynchronously mid-stream:
  - outputs go to 0 before the next clock edge, alloc_ready = 1
